// File: rtl/cpu_debug_ocimem_arbiter.sv
// Two-requester (JTAG / host) round-robin arbiter in front of the OCI debug memory.
// One transaction at a time: IDLE -> ISSUE -> (WAIT) -> ACK, with a read-latency counter.
module cpu_debug_ocimem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_DEPTH  = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              j_req,
  input  logic              j_wr,
  input  logic [ADDR_W-1:0] j_addr,
  input  logic [DATA_W-1:0] j_wdata,
  output logic              j_ack,
  output logic              j_err,
  output logic [DATA_W-1:0] j_rdata,
  input  logic              h_req,
  input  logic              h_wr,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_ack,
  output logic              h_err,
  output logic [DATA_W-1:0] h_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_j
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  // Extra top bit so MEM_DEPTH == 2**ADDR_W still fits in the compare.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [1:0]      CNT_LOAD  = 2'(RD_LATENCY - 1);

  state_t            state;
  state_t            state_nx;
  logic              last_h;
  logic              grant_q;
  logic              lat_wr;
  logic              lat_bad;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [1:0]        cnt;
  logic              acked_j;
  logic              acked_h;
  logic              elig_j;
  logic              elig_h;
  logic              pick_j;
  logic              any_req;

  // A side that was acked in the previous cycle sits out one IDLE cycle.
  assign elig_j  = j_req && !acked_j;
  assign elig_h  = h_req && !acked_h;
  assign any_req = elig_j || elig_h;
  assign pick_j  = elig_j && (!elig_h || last_h);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = (lat_wr || lat_bad) ? ACK : WAIT;
      WAIT:    if (cnt == 2'd0) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    mem_rd    = (state == ISSUE) && !lat_wr && !lat_bad;
    mem_wr    = (state == ISSUE) &&  lat_wr && !lat_bad;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    j_ack     = (state == ACK) &&  grant_q;
    h_ack     = (state == ACK) && !grant_q;
    grant_j   = grant_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_h    <= 1'b1;
      grant_q   <= 1'b0;
      lat_wr    <= 1'b0;
      lat_bad   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= 2'd0;
      acked_j   <= 1'b0;
      acked_h   <= 1'b0;
      j_err     <= 1'b0;
      j_rdata   <= '0;
      h_err     <= 1'b0;
      h_rdata   <= '0;
    end else begin
      acked_j <= (state == ACK) &&  grant_q;
      acked_h <= (state == ACK) && !grant_q;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_q   <= pick_j;
            last_h    <= !pick_j;
            lat_wr    <= pick_j ? j_wr    : h_wr;
            lat_addr  <= pick_j ? j_addr  : h_addr;
            lat_wdata <= pick_j ? j_wdata : h_wdata;
            lat_bad   <= ({1'b0, (pick_j ? j_addr : h_addr)} >= DEPTH_EXT);
          end
        end
        ISSUE: begin
          cnt <= CNT_LOAD;
          // Writes and out-of-range accesses complete with zero read data.
          if (lat_wr || lat_bad) begin
            if (grant_q) begin
              j_rdata <= '0;
              j_err   <= lat_bad;
            end else begin
              h_rdata <= '0;
              h_err   <= lat_bad;
            end
          end
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            if (grant_q) begin
              j_rdata <= mem_rdata;
              j_err   <= 1'b0;
            end else begin
              h_rdata <= mem_rdata;
              h_err   <= 1'b0;
            end
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_debug_ocimem_arbiter.sv
// Bench for cpu_debug_ocimem_arbiter: transaction-timeline model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_cpu_debug_ocimem_arbiter;

  localparam int RD    = 2;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        j_req = 1'b0, j_wr = 1'b0;
  logic [7:0]  j_addr = '0;
  logic [31:0] j_wdata = '0;
  logic        j_ack, j_err;
  logic [31:0] j_rdata;
  logic        h_req = 1'b0, h_wr = 1'b0;
  logic [7:0]  h_addr = '0;
  logic [31:0] h_wdata = '0;
  logic        h_ack, h_err;
  logic [31:0] h_rdata;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy, grant_j;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int scen_id = 0;
  int scen_t0 = 0;
  int tmo_raised = 0;

  cpu_debug_ocimem_arbiter #(
    .ADDR_W(8), .DATA_W(32), .MEM_DEPTH(DEPTH), .RD_LATENCY(RD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .j_req(j_req), .j_wr(j_wr), .j_addr(j_addr), .j_wdata(j_wdata),
    .j_ack(j_ack), .j_err(j_err), .j_rdata(j_rdata),
    .h_req(h_req), .h_wr(h_wr), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_err(h_err), .h_rdata(h_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_j(grant_j)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(input int a);
    return 32'hA500_0000 ^ 32'(a * 32'h0001_0203);
  endfunction

  // Memory responding to the DUT: data for a strobe at cycle t appears at t+RD.
  logic [31:0] mem_arr [256];
  logic [31:0] rd_pipe [RD];
  bit          mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= initWord(i);
      mem_arr[7] <= 32'h1234_5678;
      mem_init   <= 1'b1;
    end else if (mem_wr) begin
      mem_arr[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= mem_rd ? mem_arr[mem_addr] : 32'hBAD0_BAD0;
    for (int i = 1; i < RD; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD-1];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Model: a granted transaction is a timeline of offsets from its grant cycle.
  initial begin : compare_proc
    logic [31:0] model_mem [256];
    bit          m_active, m_side_j, m_wr, m_bad, m_last_h, m_grant_j, m_last_ack_j;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_j_rdata, m_h_rdata, rd;
    logic        m_j_err, m_h_err;
    int          m_start, m_ack_off, m_last_ack_cyc, off, rel, tmo_seen, scen_acks, prev_scen;
    bit          is_issue, is_ack, ej, eh;
    for (int i = 0; i < 256; i++) model_mem[i] = initWord(i);
    model_mem[7] = 32'h1234_5678;
    m_active = 0; m_last_h = 1; m_grant_j = 0; m_last_ack_cyc = -10; m_last_ack_j = 0;
    m_side_j = 0; m_wr = 0; m_bad = 0; m_addr = '0; m_wdata = '0; m_start = 0; m_ack_off = 0;
    m_j_rdata = '0; m_h_rdata = '0; m_j_err = 0; m_h_err = 0;
    tmo_seen = 0; scen_acks = 0; prev_scen = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_active = 0; m_last_h = 1; m_grant_j = 0; m_last_ack_cyc = -10;
        m_j_rdata = '0; m_h_rdata = '0; m_j_err = 0; m_h_err = 0;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_mem_rd", mem_rd, 0);
        checkOutput("rst_mem_wr", mem_wr, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_j_ack", j_ack, 0);
        checkOutput("rst_h_ack", h_ack, 0);
        checkOutput("rst_j_err", j_err, 0);
        checkOutput("rst_h_err", h_err, 0);
        checkOutput("rst_j_rdata", j_rdata, 0);
        checkOutput("rst_h_rdata", h_rdata, 0);
        checkOutput("rst_grant_j", grant_j, 0);
      end else begin
        off      = m_active ? cyc - m_start : -1;
        is_issue = m_active && off == 1;
        is_ack   = m_active && off == m_ack_off;
        if (is_ack) begin
          rd = (m_wr || m_bad) ? 32'h0 : model_mem[m_addr];
          if (m_side_j) begin m_j_rdata = rd; m_j_err = m_bad; end
          else          begin m_h_rdata = rd; m_h_err = m_bad; end
          if (m_wr && !m_bad) model_mem[m_addr] = m_wdata;
        end
        checkOutput("busy", busy, 64'(m_active && off >= 1));
        checkOutput("mem_rd", mem_rd, 64'(is_issue && !m_wr && !m_bad));
        checkOutput("mem_wr", mem_wr, 64'(is_issue && m_wr && !m_bad));
        if (is_issue) begin
          checkOutput("mem_addr", mem_addr, m_addr);
          if (m_wr) checkOutput("mem_wdata", mem_wdata, m_wdata);
        end
        checkOutput("j_ack", j_ack, 64'(is_ack && m_side_j));
        checkOutput("h_ack", h_ack, 64'(is_ack && !m_side_j));
        checkOutput("j_err", j_err, m_j_err);
        checkOutput("h_err", h_err, m_h_err);
        checkOutput("j_rdata", j_rdata, m_j_rdata);
        checkOutput("h_rdata", h_rdata, m_h_rdata);
        checkOutput("grant_j", grant_j, m_grant_j);
        if (is_ack) begin
          m_active = 0; m_last_ack_cyc = cyc; m_last_ack_j = m_side_j;
        end else if (!m_active) begin
          ej = j_req && !( m_last_ack_j && m_last_ack_cyc == cyc - 1);
          eh = h_req && !(!m_last_ack_j && m_last_ack_cyc == cyc - 1);
          if (ej || eh) begin
            m_side_j  = ej && (!eh || m_last_h);
            m_last_h  = !m_side_j;
            m_grant_j = m_side_j;
            m_wr      = m_side_j ? j_wr    : h_wr;
            m_addr    = m_side_j ? j_addr  : h_addr;
            m_wdata   = m_side_j ? j_wdata : h_wdata;
            m_bad     = int'(m_addr) >= DEPTH;
            m_ack_off = (m_wr || m_bad) ? 2 : RD + 2;
            m_start   = cyc;
            m_active  = 1;
          end
        end
      end

      // Hand-computed expectations for the directed scenarios.
      if (scen_id != prev_scen) scen_acks = 0;
      prev_scen = scen_id;
      rel = cyc - scen_t0;
      case (scen_id)
        23: begin
          if (rel == 1) begin
            checkOutput("lit23_mem_wr", mem_wr, 1);
            checkOutput("lit23_mem_addr", mem_addr, 5);
            checkOutput("lit23_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
          end
          if (rel == 2) begin
            checkOutput("lit23_j_ack", j_ack, 1);
            checkOutput("lit23_j_err", j_err, 0);
          end
        end
        24: begin
          if (rel == 1) begin
            checkOutput("lit24_mem_rd", mem_rd, 1);
            checkOutput("lit24_mem_addr", mem_addr, 7);
          end
          if (rel == 3) checkOutput("lit24_h_ack_early", h_ack, 0);
          if (rel == 4) begin
            checkOutput("lit24_h_ack", h_ack, 1);
            checkOutput("lit24_h_rdata", h_rdata, 32'h1234_5678);
          end
        end
        26: begin
          if (rel == 1) checkOutput("lit26_no_strobe", {mem_rd, mem_wr}, 0);
          if (rel == 2) begin
            checkOutput("lit26_j_ack", j_ack, 1);
            checkOutput("lit26_j_err", j_err, 1);
            checkOutput("lit26_j_rdata", j_rdata, 0);
          end
        end
        28: begin
          if (rel == 4) begin
            checkOutput("lit28_j_ack", j_ack, 1);
            checkOutput("lit28_j_rdata", j_rdata, 32'hDEAD_BEEF);
          end
        end
        25, 27: begin
          if (scen_id == 27 && rel == 2) begin
            checkOutput("lit27_busy", busy, 0);
            checkOutput("lit27_h_ack", h_ack, 0);
          end
          if (j_ack || h_ack) begin
            checkOutput("grant_order", {j_ack, h_ack}, (scen_acks % 2 == 0) ? 2'b10 : 2'b01);
            scen_acks++;
          end
        end
        default: ;
      endcase

      if (tmo_raised != tmo_seen) begin
        checkOutput("ack_timeout", 64'(tmo_raised), 64'(tmo_seen));
        tmo_seen = tmo_raised;
      end
      cyc++;
    end
  end

  // Drives one transaction, scrambles the request fields after the grant, and waits for the ack.
  task automatic applyStimulus(input bit side_j, input bit wr, input logic [7:0] addr,
                               input logic [31:0] wdata, input int scen, input bit drop);
    bit got;
    @(posedge clk); #1;
    scen_id = scen; scen_t0 = cyc;
    if (side_j) begin j_req = 1; j_wr = wr; j_addr = addr; j_wdata = wdata; end
    else        begin h_req = 1; h_wr = wr; h_addr = addr; h_wdata = wdata; end
    @(posedge clk); #1;
    if (side_j) begin j_wr = ~wr; j_addr = addr ^ 8'h3C; j_wdata = ~wdata; end
    else        begin h_wr = ~wr; h_addr = addr ^ 8'h3C; h_wdata = ~wdata; end
    @(posedge clk); #1;
    if (drop) begin
      if (side_j) j_req = 0; else h_req = 0;
    end
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (side_j ? j_ack : h_ack) got = 1;
    end
    if (!got) tmo_raised++;
    @(posedge clk); #1;
    j_req = 0; h_req = 0; scen_id = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic waitAcks(input int count, input int budget);
    int seen;
    seen = 0;
    for (int n = 0; n < budget && seen < count; n++) begin
      @(negedge clk);
      if (j_ack || h_ack) seen++;
    end
    if (seen < count) tmo_raised++;
  endtask

  initial begin : stimulus_proc
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    repeat (2) @(posedge clk);

    applyStimulus(1, 1, 8'd5,   32'hDEAD_BEEF, 23, 0);
    applyStimulus(0, 0, 8'd7,   32'h0,         24, 0);
    applyStimulus(1, 0, 8'd7,   32'h0,         30, 0);
    applyStimulus(1, 0, 8'd64,  32'h0,         26, 0);
    applyStimulus(1, 0, 8'd5,   32'h0,         28, 1);
    applyStimulus(0, 1, 8'd63,  32'hCAFE_F00D, 31, 0);
    applyStimulus(0, 0, 8'd63,  32'h0,         32, 0);
    applyStimulus(0, 1, 8'd255, 32'h1111_2222, 33, 0);

    // Continuous requests from both sides straight out of reset.
    @(posedge clk); #1 reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    scen_id = 25; scen_t0 = cyc;
    j_req = 1; j_wr = 1; j_addr = 8'd10; j_wdata = 32'h0BAD_CAFE;
    h_req = 1; h_wr = 0; h_addr = 8'd10; h_wdata = 32'h0;
    waitAcks(6, 100);
    @(posedge clk); #1;
    j_req = 0; h_req = 0; scen_id = 0;
    repeat (3) @(posedge clk);

    // Reset drops while an H read is waiting on memory.
    #1;
    scen_id = 27; scen_t0 = cyc;
    h_req = 1; h_wr = 0; h_addr = 8'd7;
    @(posedge clk); #1;
    @(posedge clk); #1 reset_n = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1;
    j_req = 1; j_wr = 0; j_addr = 8'd3;
    waitAcks(2, 40);
    @(posedge clk); #1;
    j_req = 0; h_req = 0; scen_id = 0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
